// File: rtl/pwm_pkg.sv
// Shared constants and divider state encoding for the PWM generator/meter pair.
package pwm_pkg;

    localparam int unsigned DUTY_W    = 7;
    localparam int unsigned PCT_SCALE = 100;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/pwm_seq_div.sv
// Restoring sequential divider: one quotient bit per cycle, start/done handshake.
module pwm_seq_div
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_W = 31,
    parameter int unsigned DEN_W = 24,
    parameter int unsigned OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [OUT_W-1:0] quot,
    output logic             done,
    output logic             busy
);

    localparam int unsigned STEP_W = $clog2(NUM_W + 1);

    div_state_e       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [NUM_W-1:0] nq_q, nq_d;

    logic [DEN_W:0]   trial;
    logic             ge;
    logic [DEN_W-1:0] rem_nxt;
    logic [NUM_W-1:0] q_nxt;
    logic             last;

    // Dividend shifts out the top while quotient bits shift in at the bottom.
    assign trial   = {rem_q, nq_q[NUM_W-1]};
    assign ge      = trial >= {1'b0, den_q};
    assign rem_nxt = ge ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
    assign q_nxt   = {nq_q[NUM_W-2:0], ge};
    assign last    = (state_q == StDiv) && (step_q == STEP_W'(NUM_W - 1));

    // done marks the final step so the caller can load results as DONE begins.
    assign done = last;
    assign quot = q_nxt[OUT_W-1:0];
    assign busy = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rem_d   = rem_q;
        den_d   = den_q;
        nq_d    = nq_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    nq_d    = num;
                    den_d   = den;
                    rem_d   = '0;
                    step_d  = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                rem_d  = rem_nxt;
                nq_d   = q_nxt;
                step_d = step_q + STEP_W'(1);
                if (last) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            nq_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            nq_q    <= nq_d;
        end
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period, high time and integer duty percent of an asynchronous PWM input.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              P_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              meas_valid,
    output logic              stuck,
    output logic              busy
);

    localparam int unsigned      NUM_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

    logic              sync1_q, s_q, prev_q;
    logic [CNT_W-1:0]  cnt_q, hi_cap_q, per_l_q, hi_l_q;
    logic              armed_q, seen_fall_q, stuck_q, meas_valid_q;
    logic [CNT_W-1:0]  period_q, high_time_q;
    logic [DUTY_W-1:0] duty_q;

    logic              rise, fall, timeout, start;
    logic              div_done, div_busy;
    logic [DUTY_W-1:0] div_quot;

    assign rise    = s_q & ~prev_q;
    assign fall    = ~s_q & prev_q;
    // A rise on the saturation cycle wins: the input is clearly not stuck.
    assign timeout = (cnt_q == TMO) && !stuck_q && !rise;
    assign start   = rise && armed_q && seen_fall_q && !div_busy;

    pwm_seq_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W),
        .OUT_W (DUTY_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .num   (NUM_W'(hi_cap_q) * NUM_W'(PCT_SCALE)),
        .den   (cnt_q),
        .quot  (div_quot),
        .done  (div_done),
        .busy  (div_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            s_q         <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            per_l_q     <= '0;
            hi_l_q      <= '0;
            armed_q     <= 1'b0;
            seen_fall_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            sync1_q <= P_in;
            s_q     <= sync1_q;
            prev_q  <= s_q;

            if (rise)              cnt_q <= CNT_W'(1);
            else if (cnt_q != TMO) cnt_q <= cnt_q + CNT_W'(1);

            if (fall) begin
                hi_cap_q    <= cnt_q;
                seen_fall_q <= 1'b1;
            end

            if (rise) begin
                armed_q     <= 1'b1;
                seen_fall_q <= 1'b0;
                stuck_q     <= 1'b0;
            end else if (timeout) begin
                armed_q <= 1'b0;
                stuck_q <= 1'b1;
            end

            if (start) begin
                per_l_q <= cnt_q;
                hi_l_q  <= hi_cap_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q     <= '0;
            high_time_q  <= '0;
            duty_q       <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            meas_valid_q <= div_done | timeout;
            if (div_done) begin
                period_q    <= per_l_q;
                high_time_q <= hi_l_q;
                duty_q      <= div_quot;
            end else if (timeout) begin
                period_q    <= '0;
                high_time_q <= '0;
                duty_q      <= s_q ? DUTY_W'(PCT_SCALE) : '0;
            end
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign duty_pct   = duty_q;
    assign meas_valid = meas_valid_q;
    assign stuck      = stuck_q;
    assign busy       = div_busy;

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Receive-side counterpart of the PWM generator: measures an incoming PWM waveform and reports period, high time and integer duty cycle in percent. Intended for loopback checking of the generator output and for reading external PWM sources. Operates entirely in the clk domain; the input is asynchronous and gets synchronised internally.

Parameters:
CNT_W, 24, width of period/high-time counters and outputs
TIMEOUT, 100000, cycles without a rising edge before the input is declared stuck; legal range CNT_W+9 .. 2^CNT_W-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
P_in  input  1  PWM input, asynchronous to clk
period  output  CNT_W  last measured period in clk cycles
high_time  output  CNT_W  last measured high time in clk cycles
duty_pct  output  7  floor(high_time*100/period), range 0..100
meas_valid  output  1  one-cycle pulse when outputs update
stuck  output  1  level: no rising edge for TIMEOUT cycles
busy  output  1  divider in progress

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. Reset clears every flop: period=0, high_time=0, duty_pct=0, meas_valid=0, stuck=0, busy=0, armed=0, seen_fall=0.
- Synchroniser: 2-flop sync of P_in (reset 0), then a previous-value flop. rise = s & !prev; fall = !s & prev.
- Cycle counter cnt: on a rise cycle cnt<=1, otherwise cnt<=cnt+1, saturating at TIMEOUT.
  - On fall: hi_cap<=cnt, seen_fall<=1.
  - For H high / L low synchronised cycles, hi_cap=H and cnt=H+L at the next rise.
- On rise:
  - If armed && seen_fall && !busy: latch per_l<=cnt and hi_l<=hi_cap, then start the divider.
  - Always: armed<=1, seen_fall<=0, stuck<=0.
  - A rise while busy drops that measurement. The counter still restarts.
- Divider FSM, states IDLE -> DIV -> DONE -> IDLE:
  - DIV: restoring division of hi_l*100 (CNT_W+7 bits) by per_l, one quotient bit per cycle, exactly CNT_W+7 cycles.
  - DONE (1 cycle): period<=per_l, high_time<=hi_l, duty_pct<=quotient[6:0], meas_valid=1.
  - busy=1 in DIV and DONE.
  - meas_valid rises CNT_W+8 cycles after the rise-sample edge.
- Timeout:
  - When cnt reaches TIMEOUT with stuck=0: stuck<=1, armed<=0, period<=0, high_time<=0, duty_pct<=(s ? 100 : 0), one meas_valid pulse.
  - cnt then holds at TIMEOUT and no further pulses occur.
  - The first rise after stuck clears stuck but gives no measurement, because armed was 0.
  - TIMEOUT > CNT_W+8 guarantees the divider is idle at timeout.
- Arithmetic:
  - high_time <= period always holds, so the quotient is <= 100 and truncation to 7 bits is safe.
  - The result is floor, not rounded.
- Reset mid-division aborts the division. No meas_valid until two qualifying rises after release.

Decomposition:
- Shared package pwm_pkg: DUTY_W=7, PCT_SCALE=100, divider state encoding (IDLE/DIV/DONE). The generator shares DUTY_W and PCT_SCALE.
- One sub-module: pwm_seq_div, the parameterised restoring divider with start/done handshake.
- Edge detection and the counter stay in the top module.

Test Plan:
- Reset, then drive H=60/L=40 repeatedly -> no meas_valid at first rise; at second rise +32 cycles (CNT_W=24): meas_valid, period=100, high_time=60, duty_pct=60; repeats every 100 cycles.
- H=1/L=199 -> period=200, high_time=1, duty_pct=0. H=333/L=667 -> duty_pct=33. H=999/L=1 -> duty_pct=99.
- TIMEOUT=1000, hold P_in high after valid PWM -> after 1000 cycles: stuck=1, duty_pct=100, period=0, single meas_valid. Repeat held low -> duty_pct=0.
- Resume PWM after stuck -> stuck clears at first rise; first measurement at second rise +32.
- H=10/L=10 (period 20 < 32-cycle divider) -> alternate rises dropped; meas_valid every 40 cycles, duty_pct=50, period=20.
- Assert rst_n low during DIV -> all outputs 0 immediately; after release, no meas_valid before two rises.
